// File: rtl/ffn_pkg.sv
// Shared FFN datapath definitions: FSM state encoding, default saturation
// bounds and the signed saturation helper reused by the activation stage.
package ffn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } fsm_e;

  // Saturation bounds for the default 8-bit z lanes and 24-bit accumulators.
  localparam int Z_MAX   = 127;
  localparam int Z_MIN   = -128;
  localparam int ACC_MAX = 8388607;
  localparam int ACC_MIN = -8388608;

  // Clamp a signed value into the range of a signed 'width'-bit number.
  // Valid for width in 2..31.
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] value,
                                                    input int width);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/requant_lane.sv
// Single-lane requantizer: round-half-up arithmetic right shift of an
// accumulator value followed by saturation to the output lane width.
module requant_lane
  import ffn_pkg::*;
#(
  parameter int ACC_WIDTH  = 24,
  parameter int DATA_WIDTH = 8
) (
  input  logic signed [ACC_WIDTH-1:0]  acc,
  input  logic        [4:0]            shift,
  output logic signed [DATA_WIDTH-1:0] z
);

  logic signed [ACC_WIDTH:0] acc_ext;
  logic signed [ACC_WIDTH:0] rounded;
  logic signed [ACC_WIDTH:0] shifted;
  logic signed [31:0]        wide;

  // One extra bit of headroom so adding the rounding constant cannot overflow.
  always_comb begin
    acc_ext = {acc[ACC_WIDTH-1], acc};
    rounded = acc_ext;
    if (shift != 5'd0) begin
      rounded = acc_ext + ((ACC_WIDTH + 1)'(1) << (shift - 5'd1));
    end
    shifted = rounded >>> shift;
    wide    = {{(31 - ACC_WIDTH){shifted[ACC_WIDTH]}}, shifted};
    z       = DATA_WIDTH'(sat_signed(wide, DATA_WIDTH));
  end

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates signed per-column partial sums over a programmable number of
// K-tiles, requantizes each column and presents the vector as pre-activation z.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds data stable while valid is high and ready is
// low; valid never depends combinationally on ready.
module psum_accumulator
  import ffn_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ACC_WIDTH      = 24,
  parameter int NUM_COLS       = 4,
  parameter int TILE_CNT_WIDTH = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           start_i,
  input  logic [TILE_CNT_WIDTH-1:0]      cfg_num_tiles_i,
  input  logic [4:0]                     cfg_shift_i,
  input  logic                           psum_valid_i,
  input  logic [NUM_COLS*ACC_WIDTH-1:0]  psum_i,
  output logic                           psum_ready_o,
  output logic                           z_valid_o,
  output logic [NUM_COLS*DATA_WIDTH-1:0] z_o,
  input  logic                           z_ready_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic [1:0]                     state_o
);

  fsm_e                             state_q;
  logic [TILE_CNT_WIDTH-1:0]        num_tiles_q;
  logic [TILE_CNT_WIDTH-1:0]        cnt_q;
  logic [TILE_CNT_WIDTH-1:0]        cnt_inc;
  logic [4:0]                       shift_q;
  logic signed [ACC_WIDTH-1:0]      acc_q   [NUM_COLS];
  logic signed [ACC_WIDTH-1:0]      acc_sum [NUM_COLS];
  logic [NUM_COLS*DATA_WIDTH-1:0]   z_lane;
  logic [NUM_COLS*DATA_WIDTH-1:0]   z_q;
  logic                             psum_ready_q;
  logic                             z_valid_q;
  logic                             busy_q;
  logic                             beat_acc;

  assign cnt_inc  = cnt_q + TILE_CNT_WIDTH'(1);
  assign beat_acc = psum_valid_i & psum_ready_q;

  // Per lane: saturating accumulate of the incoming beat, then requantize the
  // updated sum so the final beat's result can be registered directly.
  for (genvar c = 0; c < NUM_COLS; c++) begin : g_lane
    logic signed [ACC_WIDTH:0] raw;
    assign raw = {acc_q[c][ACC_WIDTH-1], acc_q[c]}
               + {psum_i[c*ACC_WIDTH+ACC_WIDTH-1], psum_i[c*ACC_WIDTH +: ACC_WIDTH]};
    assign acc_sum[c] = ACC_WIDTH'(sat_signed({{(31 - ACC_WIDTH){raw[ACC_WIDTH]}}, raw},
                                              ACC_WIDTH));

    requant_lane #(
      .ACC_WIDTH (ACC_WIDTH),
      .DATA_WIDTH(DATA_WIDTH)
    ) u_requant (
      .acc  (acc_sum[c]),
      .shift(shift_q),
      .z    (z_lane[c*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  // Job control FSM with registered ready/valid/busy outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      num_tiles_q  <= '0;
      cnt_q        <= '0;
      shift_q      <= '0;
      z_q          <= '0;
      psum_ready_q <= 1'b0;
      z_valid_q    <= 1'b0;
      busy_q       <= 1'b0;
      for (int c = 0; c < NUM_COLS; c++) acc_q[c] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            // A zero tile count still means one beat.
            num_tiles_q  <= (cfg_num_tiles_i == '0) ? TILE_CNT_WIDTH'(1) : cfg_num_tiles_i;
            shift_q      <= cfg_shift_i;
            cnt_q        <= '0;
            for (int c = 0; c < NUM_COLS; c++) acc_q[c] <= '0;
            state_q      <= ACCUM;
            psum_ready_q <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        ACCUM: begin
          if (beat_acc) begin
            for (int c = 0; c < NUM_COLS; c++) acc_q[c] <= acc_sum[c];
            cnt_q <= cnt_inc;
            if (cnt_inc == num_tiles_q) begin
              z_q          <= z_lane;
              state_q      <= EMIT;
              psum_ready_q <= 1'b0;
              z_valid_q    <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (z_ready_i) begin
            state_q   <= IDLE;
            z_valid_q <= 1'b0;
            busy_q    <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          psum_ready_q <= 1'b0;
          z_valid_q    <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign psum_ready_o = psum_ready_q;
  assign z_valid_o    = z_valid_q;
  assign z_o          = z_q;
  assign busy_o       = busy_q;
  assign done_o       = z_valid_q & z_ready_i;
  assign state_o      = state_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Bench for psum_accumulator: directed scenarios plus randomized back-to-back
// jobs checked against an arithmetic reference model.
module tb_psum_accumulator;

  localparam int DW = 8;
  localparam int AW = 24;
  localparam int NC = 4;
  localparam int TW = 8;
  localparam longint ACC_HI = (longint'(1) << (AW - 1)) - 1;
  localparam longint ACC_LO = -(longint'(1) << (AW - 1));
  localparam longint Z_HI   = (longint'(1) << (DW - 1)) - 1;
  localparam longint Z_LO   = -(longint'(1) << (DW - 1));

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                 start_i;
  logic [TW-1:0]        cfg_num_tiles_i;
  logic [4:0]           cfg_shift_i;
  logic                 psum_valid_i;
  logic [NC*AW-1:0]     psum_i;
  logic                 psum_ready_o;
  logic                 z_valid_o;
  logic [NC*DW-1:0]     z_o;
  logic                 z_ready_i;
  logic                 busy_o;
  logic                 done_o;
  logic [1:0]           state_o;

  psum_accumulator #(
    .DATA_WIDTH(DW), .ACC_WIDTH(AW), .NUM_COLS(NC), .TILE_CNT_WIDTH(TW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_i),
    .cfg_num_tiles_i(cfg_num_tiles_i), .cfg_shift_i(cfg_shift_i),
    .psum_valid_i(psum_valid_i), .psum_i(psum_i), .psum_ready_o(psum_ready_o),
    .z_valid_o(z_valid_o), .z_o(z_o), .z_ready_i(z_ready_i),
    .busy_o(busy_o), .done_o(done_o), .state_o(state_o)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  logic [NC*AW-1:0] beat_mem [16];
  logic [NC*DW-1:0] exp_q [$];

  always @(posedge clk) if (done_o === 1'b1) done_cnt++;

  // ---------------- reference model ----------------
  function automatic logic [NC*AW-1:0] pack4(int a, int b, int c, int d);
    logic [NC*AW-1:0] v;
    v[0*AW +: AW] = a[AW-1:0];
    v[1*AW +: AW] = b[AW-1:0];
    v[2*AW +: AW] = c[AW-1:0];
    v[3*AW +: AW] = d[AW-1:0];
    return v;
  endfunction

  // Sum with clamping, divide by 2^sh rounding half up (floor of x + 1/2), clamp.
  function automatic logic [NC*DW-1:0] model_z(int n, int sh);
    logic [NC*DW-1:0] r;
    logic signed [AW-1:0] lv;
    longint acc, num, den, q;
    r = '0;
    for (int c = 0; c < NC; c++) begin
      acc = 0;
      for (int b = 0; b < n; b++) begin
        lv  = beat_mem[b][c*AW +: AW];
        acc = acc + longint'(lv);
        if (acc > ACC_HI) acc = ACC_HI;
        if (acc < ACC_LO) acc = ACC_LO;
      end
      den = longint'(1) << sh;
      num = acc + den / 2;
      q   = num / den;
      if ((num % den != 0) && (num < 0)) q = q - 1;
      if (q > Z_HI) q = Z_HI;
      if (q < Z_LO) q = Z_LO;
      r[c*DW +: DW] = q[DW-1:0];
    end
    return r;
  endfunction

  function automatic int rnd_psum();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 16777215)) - 8388608;
    return int'($urandom_range(0, 400)) - 200;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_start(int nt, int sh);
    start_i = 1'b1;
    cfg_num_tiles_i = nt[TW-1:0];
    cfg_shift_i = sh[4:0];
    @(posedge clk); #1;
    start_i = 1'b0;
    cfg_num_tiles_i = TW'($urandom_range(0, 255));
    cfg_shift_i = 5'($urandom_range(0, 31));
  endtask

  task automatic do_beats(int n, bit gaps);
    for (int b = 0; b < n; b++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          psum_valid_i = 1'b0;
          psum_i = {$urandom(), $urandom(), $urandom()};
          @(posedge clk); #1;
        end
      end
      psum_valid_i = 1'b1;
      psum_i = beat_mem[b];
      @(posedge clk); #1;
      psum_valid_i = 1'b0;
    end
  endtask

  task automatic do_handshake(output bit done_seen);
    z_ready_i = 1'b1;
    #1;
    done_seen = done_o;
    @(posedge clk); #1;
    z_ready_i = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (z_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_z_valid: got %b want 0", z_valid_o); end
    n_cmp++; if (psum_ready_o !== 1'b0) begin n_bad++; $display("FAIL reset_psum_ready: got %b want 0", psum_ready_o); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    n_cmp++; if (done_o !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done_o); end
    n_cmp++; if (z_o !== '0) begin n_bad++; $display("FAIL reset_z: got %h want 0", z_o); end
    n_cmp++; if (state_o !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state_o); end
    n_cmp++; if (psum_ready_o !== 1'b0) begin n_bad++; $display("FAIL idle_psum_ready: got %b want 0", psum_ready_o); end
  endtask

  task automatic test_single_tile();
    logic [NC*DW-1:0] exp;
    logic [NC*DW-1:0] want;
    int d0;
    bit ds;
    beat_mem[0] = pack4(5, -3, 127, -128);
    exp_q.push_back(model_z(1, 0));
    do_start(1, 0);
    n_cmp++; if (psum_ready_o !== 1'b1) begin n_bad++; $display("FAIL single_ready: got %b want 1", psum_ready_o); end
    n_cmp++; if (busy_o !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b want 1", busy_o); end
    do_beats(1, 1'b0);
    n_cmp++; if (z_valid_o !== 1'b1) begin n_bad++; $display("FAIL single_latency: got z_valid %b want 1", z_valid_o); end
    n_cmp++; if (psum_ready_o !== 1'b0) begin n_bad++; $display("FAIL single_emit_ready: got %b want 0", psum_ready_o); end
    exp = exp_q.pop_front();
    want = {8'h80, 8'h7f, 8'hfd, 8'h05};
    n_cmp++; if (z_o !== exp) begin n_bad++; $display("FAIL single_z_model: got %h want %h", z_o, exp); end
    n_cmp++; if (z_o !== want) begin n_bad++; $display("FAIL single_z_const: got %h want %h", z_o, want); end
    n_cmp++; if (done_o !== 1'b0) begin n_bad++; $display("FAIL single_done_early: got %b want 0", done_o); end
    d0 = done_cnt;
    do_handshake(ds);
    n_cmp++; if (ds !== 1'b1) begin n_bad++; $display("FAIL single_done: got %b want 1", ds); end
    n_cmp++; if (z_valid_o !== 1'b0) begin n_bad++; $display("FAIL single_valid_drop: got %b want 0", z_valid_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL single_busy_drop: got %b want 0", busy_o); end
    n_cmp++; if (done_cnt !== d0 + 1) begin n_bad++; $display("FAIL single_done_count: got %0d want %0d", done_cnt - d0, 1); end
  endtask

  task automatic test_rounding();
    logic [NC*DW-1:0] exp;
    bit ds;
    beat_mem[0] = pack4(4, -4, rnd_psum(), rnd_psum());
    beat_mem[1] = pack4(4, -4, rnd_psum(), rnd_psum());
    beat_mem[2] = pack4(3, -3, rnd_psum(), rnd_psum());
    exp_q.push_back(model_z(3, 2));
    do_start(3, 2);
    do_beats(3, 1'b1);
    exp = exp_q.pop_front();
    n_cmp++; if (z_valid_o !== 1'b1) begin n_bad++; $display("FAIL round_valid: got %b want 1", z_valid_o); end
    n_cmp++; if (z_o[7:0] !== 8'd3) begin n_bad++; $display("FAIL round_lane0: got %h want 03", z_o[7:0]); end
    n_cmp++; if (z_o[15:8] !== 8'hfd) begin n_bad++; $display("FAIL round_lane1: got %h want fd", z_o[15:8]); end
    n_cmp++; if (z_o !== exp) begin n_bad++; $display("FAIL round_z: got %h want %h", z_o, exp); end
    do_handshake(ds);
  endtask

  task automatic test_out_sat();
    logic [NC*DW-1:0] exp;
    bit ds;
    beat_mem[0] = pack4(100, -100, 60, -64);
    beat_mem[1] = pack4(100, -100, 67, -64);
    exp_q.push_back(model_z(2, 0));
    do_start(2, 0);
    do_beats(2, 1'b0);
    exp = exp_q.pop_front();
    n_cmp++; if (z_o[7:0] !== 8'h7f) begin n_bad++; $display("FAIL osat_pos: got %h want 7f", z_o[7:0]); end
    n_cmp++; if (z_o[15:8] !== 8'h80) begin n_bad++; $display("FAIL osat_neg: got %h want 80", z_o[15:8]); end
    n_cmp++; if (z_o !== exp) begin n_bad++; $display("FAIL osat_z: got %h want %h", z_o, exp); end
    do_handshake(ds);
  endtask

  task automatic test_stalls();
    logic [NC*DW-1:0] exp;
    logic [NC*DW-1:0] held;
    int d0;
    bit ds;
    beat_mem[0] = pack4(rnd_psum(), rnd_psum(), rnd_psum(), rnd_psum());
    beat_mem[1] = pack4(rnd_psum(), rnd_psum(), rnd_psum(), rnd_psum());
    exp_q.push_back(model_z(2, 3));
    do_start(2, 3);
    d0 = done_cnt;
    psum_valid_i = 1'b1; psum_i = beat_mem[0];
    @(posedge clk); #1;
    psum_valid_i = 1'b0; psum_i = {$urandom(), $urandom(), $urandom()};
    @(posedge clk); #1;
    n_cmp++; if (z_valid_o !== 1'b0) begin n_bad++; $display("FAIL stall_invalid_counted: got z_valid %b want 0", z_valid_o); end
    psum_valid_i = 1'b1; psum_i = beat_mem[1];
    @(posedge clk); #1;
    psum_valid_i = 1'b0; psum_i = {$urandom(), $urandom(), $urandom()};
    @(posedge clk); #1;
    exp = exp_q.pop_front();
    n_cmp++; if (z_o !== exp) begin n_bad++; $display("FAIL stall_z: got %h want %h", z_o, exp); end
    held = z_o;
    for (int i = 0; i < 5; i++) begin
      psum_valid_i = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (z_valid_o !== 1'b1) begin n_bad++; $display("FAIL stall_valid_hold: cycle %0d got %b want 1", i, z_valid_o); end
      n_cmp++; if (z_o !== held) begin n_bad++; $display("FAIL stall_z_hold: cycle %0d got %h want %h", i, z_o, held); end
      n_cmp++; if (done_o !== 1'b0) begin n_bad++; $display("FAIL stall_done_early: cycle %0d got %b want 0", i, done_o); end
    end
    psum_valid_i = 1'b0;
    do_handshake(ds);
    n_cmp++; if (ds !== 1'b1) begin n_bad++; $display("FAIL stall_done: got %b want 1", ds); end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (done_cnt !== d0 + 1) begin n_bad++; $display("FAIL stall_done_once: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_acc_sat();
    logic [NC*DW-1:0] exp;
    bit ds;
    beat_mem[0] = pack4(8388607, -8388608, 4000000, -5);
    beat_mem[1] = pack4(8388607, -8388608, 4000000, -5);
    exp_q.push_back(model_z(2, 16));
    do_start(2, 16);
    do_beats(2, 1'b1);
    exp = exp_q.pop_front();
    n_cmp++; if (z_o[7:0] !== 8'h7f) begin n_bad++; $display("FAIL accsat_pos: got %h want 7f", z_o[7:0]); end
    n_cmp++; if (z_o[15:8] !== 8'h80) begin n_bad++; $display("FAIL accsat_neg: got %h want 80", z_o[15:8]); end
    n_cmp++; if (z_o !== exp) begin n_bad++; $display("FAIL accsat_z: got %h want %h", z_o, exp); end
    do_handshake(ds);
  endtask

  task automatic test_zero_tiles();
    logic [NC*DW-1:0] exp;
    int sh;
    bit ds;
    sh = int'($urandom_range(0, 6));
    beat_mem[0] = pack4(rnd_psum(), rnd_psum(), 77, -90);
    exp_q.push_back(model_z(1, sh));
    do_start(0, sh);
    do_beats(1, 1'b0);
    exp = exp_q.pop_front();
    n_cmp++; if (z_valid_o !== 1'b1) begin n_bad++; $display("FAIL zero_tiles_valid: got %b want 1", z_valid_o); end
    n_cmp++; if (z_o !== exp) begin n_bad++; $display("FAIL zero_tiles_z: got %h want %h", z_o, exp); end
    do_handshake(ds);
    n_cmp++; if (ds !== 1'b1) begin n_bad++; $display("FAIL zero_tiles_done: got %b want 1", ds); end
  endtask

  task automatic test_reset_mid();
    logic [NC*DW-1:0] exp;
    bit ds;
    beat_mem[0] = pack4(rnd_psum(), rnd_psum(), rnd_psum(), rnd_psum());
    do_start(3, 1);
    do_beats(1, 1'b0);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (psum_ready_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_ready: got %b want 0", psum_ready_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", busy_o); end
    n_cmp++; if (z_valid_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid: got %b want 0", z_valid_o); end
    n_cmp++; if (z_o !== '0) begin n_bad++; $display("FAIL rstmid_z: got %h want 0", z_o); end
    n_cmp++; if (state_o !== 2'd0) begin n_bad++; $display("FAIL rstmid_state: got %0d want 0", state_o); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    beat_mem[0] = pack4(rnd_psum(), rnd_psum(), rnd_psum(), rnd_psum());
    exp_q.push_back(model_z(1, 0));
    do_start(1, 0);
    do_beats(1, 1'b0);
    exp = exp_q.pop_front();
    n_cmp++; if (z_o !== exp) begin n_bad++; $display("FAIL rstmid_recover_z: got %h want %h", z_o, exp); end
    do_handshake(ds);
  endtask

  task automatic test_start_filter();
    logic [NC*DW-1:0] exp;
    int d0;
    bit ds;
    beat_mem[0] = pack4(rnd_psum(), rnd_psum(), rnd_psum(), rnd_psum());
    beat_mem[1] = pack4(rnd_psum(), rnd_psum(), rnd_psum(), rnd_psum());
    exp_q.push_back(model_z(2, 4));
    do_start(2, 4);
    // A start during accumulation must not restart the job.
    start_i = 1'b1; cfg_num_tiles_i = 8'd1;
    do_beats(1, 1'b0);
    start_i = 1'b0;
    n_cmp++; if (z_valid_o !== 1'b0) begin n_bad++; $display("FAIL sfilt_accum_restart: got z_valid %b want 0", z_valid_o); end
    do_beats(0, 1'b0);
    psum_valid_i = 1'b1; psum_i = beat_mem[1];
    @(posedge clk); #1;
    psum_valid_i = 1'b0;
    exp = exp_q.pop_front();
    n_cmp++; if (z_o !== exp) begin n_bad++; $display("FAIL sfilt_z: got %h want %h", z_o, exp); end
    d0 = done_cnt;
    start_i = 1'b1; cfg_num_tiles_i = 8'd5;
    repeat (2) @(posedge clk);
    #1;
    start_i = 1'b0;
    n_cmp++; if (state_o !== 2'd2) begin n_bad++; $display("FAIL sfilt_emit_state: got %0d want 2", state_o); end
    n_cmp++; if (z_o !== exp) begin n_bad++; $display("FAIL sfilt_z_hold: got %h want %h", z_o, exp); end
    do_handshake(ds);
    psum_valid_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    psum_valid_i = 1'b0;
    n_cmp++; if (state_o !== 2'd0) begin n_bad++; $display("FAIL sfilt_idle_state: got %0d want 0", state_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL sfilt_busy: got %b want 0", busy_o); end
    n_cmp++; if (done_cnt !== d0 + 1) begin n_bad++; $display("FAIL sfilt_job_count: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_back_to_back();
    logic [NC*DW-1:0] exp;
    int nt, n, sh, d0, dly;
    bit ds;
    d0 = done_cnt;
    for (int j = 0; j < 25; j++) begin
      nt = int'($urandom_range(1, 5));
      if ($urandom_range(0, 7) == 0) nt = 0;
      n  = (nt == 0) ? 1 : nt;
      sh = int'($urandom_range(0, AW - 1));
      for (int b = 0; b < n; b++) beat_mem[b] = pack4(rnd_psum(), rnd_psum(), rnd_psum(), rnd_psum());
      exp_q.push_back(model_z(n, sh));
      z_ready_i = 1'($urandom_range(0, 1));
      do_start(nt, sh);
      do_beats(n, 1'($urandom_range(0, 1)));
      exp = exp_q.pop_front();
      n_cmp++; if (z_valid_o !== 1'b1) begin n_bad++; $display("FAIL b2b_valid: job %0d got %b want 1", j, z_valid_o); end
      n_cmp++; if (z_o !== exp) begin n_bad++; $display("FAIL b2b_z: job %0d nt %0d sh %0d got %h want %h", j, nt, sh, z_o, exp); end
      if (z_ready_i) begin
        n_cmp++; if (done_o !== 1'b1) begin n_bad++; $display("FAIL b2b_done_early_ready: job %0d got %b want 1", j, done_o); end
        @(posedge clk); #1;
        z_ready_i = 1'b0;
      end else begin
        dly = int'($urandom_range(0, 3));
        repeat (dly) @(posedge clk);
        #1;
        do_handshake(ds);
        n_cmp++; if (ds !== 1'b1) begin n_bad++; $display("FAIL b2b_done: job %0d got %b want 1", j, ds); end
      end
      n_cmp++; if (z_valid_o !== 1'b0) begin n_bad++; $display("FAIL b2b_valid_drop: job %0d got %b want 0", j, z_valid_o); end
    end
    n_cmp++; if (done_cnt !== d0 + 25) begin n_bad++; $display("FAIL b2b_job_count: got %0d want 25", done_cnt - d0); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b0;
    start_i = 1'b0;
    cfg_num_tiles_i = '0;
    cfg_shift_i = '0;
    psum_valid_i = 1'b0;
    psum_i = '0;
    z_ready_i = 1'b0;
    test_reset();
    test_single_tile();
    test_rounding();
    test_out_sat();
    test_stalls();
    test_acc_sat();
    test_zero_tiles();
    test_reset_mid();
    test_start_filter();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached, got no completion want completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/psum_accumulator.md
Name: psum_accumulator

Overview:
Sits directly upstream of the activation stage in the FFN datapath. Accumulates signed partial sums from the systolic array's NUM_COLS column outputs over a programmable number of K-tiles. Then requantizes each column sum (rounding arithmetic right shift plus saturation) to DATA_WIDTH. Presents the requantized vector as pre-activation z values over a valid/ready handshake.

Parameters:
DATA_WIDTH, 8, width of each requantized output lane (matches activation input width)
ACC_WIDTH, 24, signed width of each incoming partial sum and each internal accumulator
NUM_COLS, 4, number of systolic array columns / lanes
TILE_CNT_WIDTH, 8, width of the tile-count configuration

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_ni  input  1  asynchronous active-low reset
start_i  input  1  starts one accumulation job; sampled only in IDLE
cfg_num_tiles_i  input  TILE_CNT_WIDTH  number of psum beats per job; latched on start
cfg_shift_i  input  5  requant right-shift amount, 0..ACC_WIDTH-1; latched on start
psum_valid_i  input  1  partial-sum beat valid
psum_i  input  NUM_COLS*ACC_WIDTH  signed partial sums; lane c at bits [c*ACC_WIDTH +: ACC_WIDTH]
psum_ready_o  output  1  accumulator can accept a beat
z_valid_o  output  1  requantized vector valid
z_o  output  NUM_COLS*DATA_WIDTH  signed requantized lanes, same packing rule
z_ready_i  input  1  downstream accepts z_o
busy_o  output  1  high in ACCUM or EMIT
done_o  output  1  one-cycle pulse on the z handshake cycle

Behaviour:
- Reset (async assert, sync release): FSM=IDLE; accumulators, tile counter and z_o = 0; psum_ready_o, z_valid_o, busy_o and done_o = 0. Reset mid-job discards the job with no output.
- IDLE:
  - psum_ready_o=0.
  - On start_i=1: latch cfg_num_tiles_i (0 is treated as 1) and cfg_shift_i; clear accumulators and counter; next state ACCUM.
- ACCUM:
  - psum_ready_o=1.
  - A beat is accepted when psum_valid_i && psum_ready_o.
  - Per lane, acc <= sat_ACC(acc + psum): compute at ACC_WIDTH+1 bits, then clamp to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]. No wrap-around.
  - The counter increments per accepted beat.
  - On the beat that makes count == num_tiles: compute the requant from the updated sum and register it into z_o; next state EMIT.
  - Latency: z_valid_o is high the cycle after the last beat is accepted.
- Requant per lane:
  - If shift>0: r = (acc + 2^(shift-1)) >>> shift, computed at ACC_WIDTH+1 bits (round half up). If shift==0: r = acc.
  - Saturate r to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- EMIT:
  - psum_ready_o=0. z_valid_o=1, and z_o is held stable until z_ready_i.
  - On the handshake: done_o=1 that cycle; next state IDLE with z_valid_o=0 the following cycle.
- start_i is ignored outside IDLE. psum_valid_i is ignored outside ACCUM.
- z_ready_i may be high before z_valid_o; this has no effect.
- Back-to-back jobs: start_i in the cycle after done_o begins a new job. Minimum turnaround is start + num_tiles beats + 1 emit cycle.

Decomposition:
- Shared package ffn_pkg: typedef fsm_e {IDLE, ACCUM, EMIT}; localparams for the saturation bounds; a function sat_signed(value, width). The activation stage reuses sat_signed.
- One sub-module, requant_lane: combinational rounding shift plus saturation for a single lane. It is instantiated NUM_COLS times via generate.

Test Plan:
- Single tile: num_tiles=1, shift=0, psum lanes {5,-3,127,-128} -> one cycle later z_valid_o=1, z_o={5,-3,127,-128}; done_o pulses on z_ready_i.
- Multi-tile with rounding: num_tiles=3, shift=2, lane0 beats 4,4,3 (sum 11) -> (11+2)>>>2 = 3; lane1 beats -4,-4,-3 (sum -11) -> (-11+2)>>>2 = -3.
- Output saturation: num_tiles=2, shift=0, lane0 beats 100,100 -> 127; lane1 beats -100,-100 -> -128.
- Backpressure and stalls: psum_valid_i toggled 1,0,1,0 with num_tiles=2 -> only valid beats are counted; z_ready_i held low 5 cycles -> z_o stable and z_valid_o high throughout; done_o pulses exactly once.
- Accumulator saturation and config edge cases:
  - ACC_WIDTH=24, two beats of 0x7FFFFF with shift=16 -> acc clamps at 8388607, result 127 (saturated).
  - cfg_num_tiles_i=0 behaves as 1.
- Reset and start filtering: assert rst_ni low mid-ACCUM after 1 of 3 beats -> all outputs 0 immediately. start_i asserted during EMIT -> ignored and job count unchanged.
